// File: rtl/write_back_unit_pkg.sv
// rtl/write_back_unit_pkg.sv - shared types and constants for the write-back stage
//
// Purpose: FSM state type and the source-index map agreed with the integrator.
// Ports:   none (package).
package wb_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      PEND_SP = 1'b1
   } wb_state_t;

   localparam int unsigned SRC_ZERO = 0;
   localparam int unsigned SRC_PORT = 1;
   localparam int unsigned SRC_ALU  = 2;
   localparam int unsigned SRC_MEM  = 3;
   localparam int unsigned SRC_SUB  = 4;
   localparam int unsigned SRC_IMM  = 5;

endpackage

// File: rtl/write_back_unit_if.sv
// rtl/write_back_unit_if.sv - MEM/WB to register-file bus of the write-back stage
//
// Purpose: bundles the MEM/WB handshake, the source/control fields and the
//          register-file write port.
// Ports:   master - MEM/WB side (drives instruction fields, sees write port)
//          slave  - write_back_unit side
interface write_back_unit_if #(
   parameter int DATA_W  = 8,
   parameter int NUM_SRC = 8,
   parameter int SEL_W   = $clog2(NUM_SRC),
   parameter int ADDR_W  = 2,
   parameter int CNT_W   = 16
) ();

   logic                      wb_valid_i;
   logic                      wb_ready_o;
   logic [NUM_SRC*DATA_W-1:0] src_data_i;
   logic [SEL_W-1:0]          src_sel_i;
   logic [ADDR_W-1:0]         rd_addr_i;
   logic                      rd_wen_i;
   logic                      sp_wen_i;
   logic [DATA_W-1:0]         sp_data_i;
   logic                      rf_wen_o;
   logic [ADDR_W-1:0]         rf_waddr_o;
   logic [DATA_W-1:0]         rf_wdata_o;
   logic [CNT_W-1:0]          retire_cnt_o;

   modport master (
      output wb_valid_i, src_data_i, src_sel_i, rd_addr_i, rd_wen_i, sp_wen_i, sp_data_i,
      input  wb_ready_o, rf_wen_o, rf_waddr_o, rf_wdata_o, retire_cnt_o
   );

   modport slave (
      input  wb_valid_i, src_data_i, src_sel_i, rd_addr_i, rd_wen_i, sp_wen_i, sp_data_i,
      output wb_ready_o, rf_wen_o, rf_waddr_o, rf_wdata_o, retire_cnt_o
   );

endinterface

// File: rtl/write_back_unit_mux.sv
// rtl/write_back_unit_mux.sv - N-to-1 source multiplexer with zero default
//
// Purpose: picks one DATA_W slice from a flattened source vector.
// Ports:   data (NUM_SRC*DATA_W, in), sel (SEL_W, in), out (DATA_W, out)
module mux_n_1 #(
   parameter int DATA_W  = 8,
   parameter int NUM_SRC = 8,
   parameter int SEL_W   = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC*DATA_W-1:0] data,
   input  logic [SEL_W-1:0]          sel,
   output logic [DATA_W-1:0]         out
);

   // Selects with no matching source (sel >= NUM_SRC) fall through to zero.
   always_comb begin
      out = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (sel == SEL_W'(k)) begin
            out = data[k*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/write_back_unit.sv
// rtl/write_back_unit.sv - write-back stage driving the single register-file write port
//
// Purpose: selects the Rd result, registers the register-file write, and splits
//          Rd+SP updates (PUSH/POP/CALL/RET) into two consecutive write cycles.
// Ports:   clk   - clock, rising edge
//          rst_n - synchronous active-low reset
//          bus   - write_back_unit_if.slave (MEM/WB handshake, sources, write port)
module write_back_unit
   import wb_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int NUM_SRC = 8,
   parameter int SEL_W   = $clog2(NUM_SRC),
   parameter int ADDR_W  = 2,
   parameter int SP_ADDR = 3,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   write_back_unit_if.slave   bus
);

   localparam logic [ADDR_W-1:0] SP_A = ADDR_W'(SP_ADDR);

   wb_state_t         state;
   wb_state_t         state_next;
   logic              ready;
   logic              accept;
   logic              dual;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] pend_data;
   logic              wen_next;
   logic [ADDR_W-1:0] waddr_next;
   logic [DATA_W-1:0] wdata_next;
   logic              rf_wen;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [CNT_W-1:0]  retire_cnt;

   mux_n_1 #(
      .DATA_W  (DATA_W),
      .NUM_SRC (NUM_SRC),
      .SEL_W   (SEL_W)
   ) u_rd_mux (
      .data (bus.src_data_i),
      .sel  (bus.src_sel_i),
      .out  (rd_data)
   );

   assign ready  = (state == IDLE);
   assign accept = bus.wb_valid_i && ready;
   // Rd targeting SP itself collapses to a single write; the Rd value wins.
   assign dual   = bus.rd_wen_i && bus.sp_wen_i && (bus.rd_addr_i != SP_A);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept && dual) state_next = PEND_SP;
         PEND_SP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Address/data default to their current value so an idle cycle holds them.
   always_comb begin
      wen_next   = 1'b0;
      waddr_next = rf_waddr;
      wdata_next = rf_wdata;
      case (state)
         IDLE: begin
            if (accept && bus.rd_wen_i) begin
               wen_next   = 1'b1;
               waddr_next = bus.rd_addr_i;
               wdata_next = rd_data;
            end else if (accept && bus.sp_wen_i) begin
               wen_next   = 1'b1;
               waddr_next = SP_A;
               wdata_next = bus.sp_data_i;
            end
         end
         PEND_SP: begin
            wen_next   = 1'b1;
            waddr_next = SP_A;
            wdata_next = pend_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rf_wen     <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
         pend_data  <= '0;
         retire_cnt <= '0;
      end else begin
         rf_wen   <= wen_next;
         rf_waddr <= waddr_next;
         rf_wdata <= wdata_next;
         if (accept && dual) begin
            pend_data <= bus.sp_data_i;
         end
         if (accept) begin
            retire_cnt <= retire_cnt + 1'b1;
         end
      end
   end

   assign bus.wb_ready_o   = ready;
   assign bus.rf_wen_o     = rf_wen;
   assign bus.rf_waddr_o   = rf_waddr;
   assign bus.rf_wdata_o   = rf_wdata;
   assign bus.retire_cnt_o = retire_cnt;

endmodule

// File: tb/tb_write_back_unit.sv
// tb/tb_write_back_unit.sv - directed self-checking bench for write_back_unit
//
// Purpose: drives hand-built instruction vectors and compares the register-file
//          write port, ready and retire counter against hand-computed values.
// Ports:   none (top-level bench).
module tb_write_back_unit;
   import wb_pkg::*;

   localparam int DATA_W  = 8;
   localparam int NUM_SRC = 6;
   localparam int SEL_W   = 3;
   localparam int ADDR_W  = 2;
   localparam int CNT_W   = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   write_back_unit_if #(
      .DATA_W (DATA_W), .NUM_SRC (NUM_SRC), .SEL_W (SEL_W),
      .ADDR_W (ADDR_W), .CNT_W (CNT_W)
   ) bus ();

   write_back_unit #(
      .DATA_W (DATA_W), .NUM_SRC (NUM_SRC), .SEL_W (SEL_W),
      .ADDR_W (ADDR_W), .SP_ADDR (3), .CNT_W (CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic valid, input logic [SEL_W-1:0] sel, input logic [ADDR_W-1:0] rd,
                        input logic rd_wen, input logic sp_wen, input logic [DATA_W-1:0] sp_data);
      bus.wb_valid_i = valid;
      bus.src_sel_i  = sel;
      bus.rd_addr_i  = rd;
      bus.rd_wen_i   = rd_wen;
      bus.sp_wen_i   = sp_wen;
      bus.sp_data_i  = sp_data;
   endtask

   task automatic check_wr(input string tag, input logic wen, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, input logic rdy, input logic [CNT_W-1:0] cnt);
      check_val({tag, ".wen"},   32'(bus.rf_wen_o),     32'(wen));
      check_val({tag, ".addr"},  32'(bus.rf_waddr_o),   32'(addr));
      check_val({tag, ".data"},  32'(bus.rf_wdata_o),   32'(data));
      check_val({tag, ".ready"}, 32'(bus.wb_ready_o),   32'(rdy));
      check_val({tag, ".cnt"},   32'(bus.retire_cnt_o), 32'(cnt));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      // zero, port, alu, mem, sub, imm
      bus.src_data_i = {8'h10, 8'h44, 8'h33, 8'h5A, 8'h11, 8'h00};
      rst_n = 1'b0;
      drive(1'b1, 3'(SRC_ALU), 2'd1, 1'b1, 1'b1, 8'hAB);
      @(negedge clk);
      repeat (3) step();
      check_wr("reset", 1'b0, 2'd0, 8'h00, 1'b1, 4'd0);
      drive(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 8'h00);
      rst_n = 1'b1;
      step();
      check_wr("post_reset", 1'b0, 2'd0, 8'h00, 1'b1, 4'd0);

      // Single Rd write from the ALU
      drive(1'b1, 3'(SRC_ALU), 2'd1, 1'b1, 1'b0, 8'h00);
      step();
      drive(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 8'h00);
      check_wr("single", 1'b1, 2'd1, 8'h5A, 1'b1, 4'd1);
      step();
      check_wr("idle_hold", 1'b0, 2'd1, 8'h5A, 1'b1, 4'd1);

      // POP: Rd from memory then SP; a queued instruction waits out the stall
      drive(1'b1, 3'(SRC_MEM), 2'd2, 1'b1, 1'b1, 8'h7F);
      step();
      drive(1'b1, 3'(SRC_SUB), 2'd0, 1'b1, 1'b0, 8'h00);
      check_wr("pop_t1", 1'b1, 2'd2, 8'h33, 1'b0, 4'd2);
      step();
      check_wr("pop_t2", 1'b1, 2'd3, 8'h7F, 1'b1, 4'd2);
      step();
      drive(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 8'h00);
      check_wr("after_pop", 1'b1, 2'd0, 8'h44, 1'b1, 4'd3);

      // Rd == SP: single write of the Rd value
      drive(1'b1, 3'(SRC_IMM), 2'd3, 1'b1, 1'b1, 8'hEE);
      step();
      drive(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 8'h00);
      check_wr("conflict_t1", 1'b1, 2'd3, 8'h10, 1'b1, 4'd4);
      step();
      check_wr("conflict_t2", 1'b0, 2'd3, 8'h10, 1'b1, 4'd4);

      // SP-only write
      drive(1'b1, 3'(SRC_PORT), 2'd1, 1'b0, 1'b1, 8'h21);
      step();
      drive(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 8'h00);
      check_wr("sp_only", 1'b1, 2'd3, 8'h21, 1'b1, 4'd5);

      // No-write instruction still retires
      drive(1'b1, 3'(SRC_ALU), 2'd2, 1'b0, 1'b0, 8'h55);
      step();
      drive(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 8'h00);
      check_wr("no_write", 1'b0, 2'd3, 8'h21, 1'b1, 4'd6);

      // Reset during PEND_SP discards the SP write
      drive(1'b1, 3'(SRC_PORT), 2'd1, 1'b1, 1'b1, 8'h99);
      step();
      drive(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 8'h00);
      check_wr("rstpend_t1", 1'b1, 2'd1, 8'h11, 1'b0, 4'd7);
      rst_n = 1'b0;
      step();
      check_wr("rstpend_t2", 1'b0, 2'd0, 8'h00, 1'b1, 4'd0);
      rst_n = 1'b1;
      step();
      check_wr("rstpend_t3", 1'b0, 2'd0, 8'h00, 1'b1, 4'd0);

      // Out-of-range select reads as zero
      drive(1'b1, 3'd7, 2'd2, 1'b1, 1'b0, 8'h00);
      step();
      drive(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 8'h00);
      check_wr("sel_oor", 1'b1, 2'd2, 8'h00, 1'b1, 4'd1);

      // Fifteen more accepts: sixteen since reset wraps the 4-bit counter to 0
      drive(1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 15; i++) begin
         step();
         check_val("wrap_ready", 32'(bus.wb_ready_o), 32'd1);
      end
      drive(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 8'h00);
      check_val("wrap_cnt", 32'(bus.retire_cnt_o), 32'd0);
      step();
      check_val("wrap_hold", 32'(bus.retire_cnt_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/write_back_unit.md
# write_back_unit

Parametrised write-back stage for the pipelined processor. Selects one of NUM_SRC result sources (zero, input port, ALU, data memory, subtractor, immediate, spares) and drives the single register-file write port through a registered output. It also serialises instructions that update both a destination register and SP (PUSH/POP/CALL/RET) into two write-port cycles, back-pressuring MEM/WB. The block sits between the MEM/WB pipeline register and the register file.

## Interface
Parameters:
- DATA_W, 8, datapath width
- NUM_SRC, 8, number of write-back sources; source 0 is tied to zero by the integrator
- SEL_W, $clog2(NUM_SRC), source-select width
- ADDR_W, 2, register-file address width
- SP_ADDR, 3, register-file address holding SP
- CNT_W, 16, retire-counter width

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous active-low reset
- wb_valid_i  in  1  MEM/WB holds a valid instruction
- wb_ready_o  out  1  block accepts this cycle; MEM/WB stalls when low
- src_data_i  in  NUM_SRC*DATA_W  flattened sources; source k at bits [k*DATA_W +: DATA_W]
- src_sel_i  in  SEL_W  source select for the Rd write
- rd_addr_i  in  ADDR_W  destination register
- rd_wen_i  in  1  instruction writes Rd
- sp_wen_i  in  1  instruction writes SP
- sp_data_i  in  DATA_W  new SP value (subtractor/adder output)
- rf_wen_o  out  1  register-file write enable (registered)
- rf_waddr_o  out  ADDR_W  write address (registered)
- rf_wdata_o  out  DATA_W  write data (registered)
- retire_cnt_o  out  CNT_W  accepted-instruction count

## Operation
- Accept: wb_valid_i && wb_ready_o. wb_ready_o = (state == IDLE), combinational from state only.
- Rd data = src_data_i[src_sel_i]. If src_sel_i >= NUM_SRC, data = 0.
- FSM states: IDLE, PEND_SP.
- IDLE, accept, rd_wen only: next cycle write (rd_addr_i, Rd data); stay IDLE.
- IDLE, accept, sp_wen only: next cycle write (SP_ADDR, sp_data_i); stay IDLE.
- IDLE, accept, both, rd_addr_i != SP_ADDR: next cycle write Rd; capture sp_data_i into pending register; go PEND_SP.
- IDLE, accept, both, rd_addr_i == SP_ADDR: Rd write wins; SP write dropped; single cycle; stay IDLE.
- IDLE, accept, neither: no write; counter still increments.
- PEND_SP: next cycle write (SP_ADDR, pending data); go IDLE. Inputs ignored.
- No write issued: rf_wen_o = 0; rf_waddr_o / rf_wdata_o hold their last value.
- retire_cnt_o increments by 1 per accept, wraps modulo 2^CNT_W.

## Timing
- Reset: state IDLE, rf_wen_o 0, rf_waddr_o 0, rf_wdata_o 0, retire_cnt_o 0, pending register 0; wb_ready_o 1 in the first cycle after reset release.
- Latency: accept in cycle T, first write visible on outputs in cycle T+1; second (SP) write in cycle T+2.
- Dual write: wb_ready_o low in cycle T+1 only; next accept no earlier than T+2. Throughput 1 instruction/cycle, 1 per 2 cycles for dual writes.
- Reset asserted while in PEND_SP: pending SP write discarded; outputs take reset values at that edge.
- retire_cnt_o updates at the same edge the first write is registered.

## Structure
- Package wb_pkg: wb_state_t enum (IDLE, PEND_SP); source-index constants SRC_ZERO=0, SRC_PORT=1, SRC_ALU=2, SRC_MEM=3, SRC_SUB=4, SRC_IMM=5.
- One sub-module: mux_n_1 (parametrised by NUM_SRC and DATA_W; out-of-range select gives 0), instantiated for Rd data.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with wb_valid_i=1 -> rf_wen_o=0, retire_cnt_o=0, wb_ready_o=1 after release.
- Single write: sel=SRC_ALU, ALU=0x5A, rd=1, rd_wen=1 -> next cycle rf_wen_o=1, addr=1, data=0x5A; ready stays 1; counter=1.
- Dual write (POP): sel=SRC_MEM=0x33, rd=2, sp_data=0x7F, both wen -> T+1 write (2,0x33), ready=0; T+2 write (3,0x7F), ready=1.
- Conflict: rd=SP_ADDR=3, both wen, sel=SRC_IMM=0x10, sp_data=0xEE -> single write (3,0x10); no T+2 write; ready never low.
- Reset in PEND_SP: assert rst_n=0 in cycle T+1 of a dual write -> no SP write at T+2; all outputs reset.
- Wrap/out-of-range: CNT_W=4, 16 accepts -> retire_cnt_o=0; src_sel_i=7 with NUM_SRC=6 -> rf_wdata_o=0x00.
